// File: rtl/fifo_uart_tx_if.sv
// Purpose: read-side link between a show-ahead byte FIFO and its serial drainer.
// Latency: none, plain wires; the consumer's pop strobe is combinational.
// Backpressure: the consumer pops only when it is ready to start a frame.
//
// Signals:
//   fifo_data_out  8  head byte, valid whenever fifo_is_empty=0
//   fifo_is_empty  1  FIFO empty flag
//   fifo_read      1  one-cycle pop strobe from the consumer
// Modports: master = FIFO side, slave = consumer side.
interface fifo_uart_tx_if;
  logic [7:0] fifo_data_out;
  logic       fifo_is_empty;
  logic       fifo_read;

  modport master (
    output fifo_data_out,
    output fifo_is_empty,
    input  fifo_read
  );

  modport slave (
    input  fifo_data_out,
    input  fifo_is_empty,
    output fifo_read
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Purpose: drains bytes from a FIFO and sends them as UART frames (start, 8 data LSB first, opt. parity, 1-2 stop).
// Latency: tx falls the cycle after fifo_read; frame is (10+PARITY_EN+STOP_BITS-1)*CLKS_PER_BIT cycles.
// Backpressure: pops only in IDLE or on the last stop cycle, and only while enable=1 and the FIFO is non-empty.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         1 permits starting new frames (a frame in flight always completes)
//   fifo           slave side of fifo_uart_tx_if (head byte, empty flag, pop strobe)
//   tx             serial line, idles high
//   busy           high while a frame is in progress
//   frame_done     one-cycle pulse after each completed frame
//   frames_sent    wrapping count of completed frames
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  fifo_uart_tx_if.slave        fifo,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          frames_sent
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic           HAS_PAR   = (PARITY_EN != 0);
  localparam logic           ODD       = (PARITY_ODD != 0);
  // Index of the final stop bit (0 for one stop bit, 1 for two).
  localparam logic           LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic          stop_q;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          tx_d;
  logic          bit_end;
  logic          final_stop;
  logic          load;

  assign bit_end    = (state_q != IDLE) && (baud_q == BAUD_LAST);
  assign final_stop = (state_q == STOP) && bit_end && (stop_q == LAST_STOP);
  // Gated by rst_n so nothing is popped while the block is held in reset.
  assign load       = rst_n && enable && !fifo.fifo_is_empty &&
                      ((state_q == IDLE) || final_stop);
  assign fifo.fifo_read = load;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = 1'b1;

    if (load) begin
      state_d = START;
      shreg_d = fifo.fifo_data_out;
      par_d   = ^fifo.fifo_data_out ^ ODD;
    end else if (bit_end) begin
      case (state_q)
        START:  state_d = DATA;
        DATA: begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = HAS_PAR ? PARITY : STOP;
        end
        PARITY: state_d = STOP;
        STOP:   if (final_stop) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Line level is chosen from the next state so tx lines up with state_q.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frames_sent <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tx         <= tx_d;
      busy       <= (state_d != IDLE);
      frame_done <= final_stop;
      if (final_stop) frames_sent <= frames_sent + 16'd1;

      if (load || bit_end || (state_q == IDLE)) baud_q <= '0;
      else                                      baud_q <= baud_q + 1'b1;

      if (load)                             bit_q <= '0;
      else if ((state_q == DATA) && bit_end) bit_q <= bit_q + 3'd1;

      if (load)                             stop_q <= 1'b0;
      else if ((state_q == STOP) && bit_end) stop_q <= ~stop_q;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Purpose: self-checking bench for fifo_uart_tx; four instances cover plain, even/odd parity and two-stop-bit frames.
// Latency: each instance is fed by a small behavioural show-ahead FIFO; tx is compared every cycle of a frame.
// Backpressure: enable is toggled per instance to exercise the hold-off path.
module tb_fifo_uart_tx;
  localparam int N   = 4;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0] en, rd, empty, tx, busy, done;
  logic [15:0]  sent [N];
  logic [7:0]   mem [N][64];
  int           wp [N] = '{0, 0, 0, 0};
  int           rp [N] = '{0, 0, 0, 0};
  logic [N-1:0] uflow = '0;
  int           exp_sent [N];
  int           nchk = 0;
  int           nerr = 0;

  // Instance 0: plain 8N1; 1: even parity; 2: odd parity; 3: two stop bits.
  for (genvar g = 0; g < N; g++) begin : g_dut
    fifo_uart_tx_if ifc ();
    assign ifc.fifo_data_out = mem[g][rp[g][5:0]];
    assign ifc.fifo_is_empty = (wp[g] == rp[g]);
    assign empty[g]          = (wp[g] == rp[g]);
    assign rd[g]             = ifc.fifo_read;

    fifo_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD  ((g == 2) ? 1 : 0),
      .STOP_BITS   ((g == 3) ? 2 : 1)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (en[g]),
      .fifo       (ifc),
      .tx         (tx[g]),
      .busy       (busy[g]),
      .frame_done (done[g]),
      .frames_sent(sent[g])
    );
  end

  // FIFO read side: pop on strobe, flag any pop from an empty FIFO.
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (rd[i]) begin
        if (empty[i]) uflow[i] <= 1'b1;
        rp[i] <= rp[i] + 1;
      end

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic [11:0] frame;  // expected tx bit sequence, bit 0 first
    int         nbits;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    mem[i][wp[i][5:0]] = b;
    wp[i] = wp[i] + 1;
  endtask

  function automatic logic [11:0] f1(input logic [7:0] b);
    return {3'b001, b, 1'b0};
  endfunction

  function automatic logic [11:0] f2(input logic [7:0] b);
    return {3'b011, b, 1'b0};
  endfunction

  // Called at the negedge of the first START cycle. Returns at the negedge
  // following the final stop cycle, which is START cycle 1 of the next frame
  // when chained.
  task automatic run_frame(input int i, input logic [11:0] fr, input int n,
                           input bit chained, input int drop_at, input string name);
    int bad;
    bad = 0;
    for (int k = 0; k < n * CPB; k++) begin
      if (tx[i] !== fr[k / CPB] || busy[i] !== 1'b1) bad++;
      if (k == n * CPB - 1) chk({name, " pop at last stop"}, int'(rd[i]), int'(chained));
      else if (rd[i]) bad++;
      if (k == drop_at) en[i] = 1'b0;
      @(negedge clk);
    end
    chk({name, " bits"}, bad, 0);
    exp_sent[i]++;
    chk({name, " done"}, int'(done[i]), 1);
    chk({name, " count"}, int'(sent[i]), exp_sent[i]);
    chk({name, " busy after"}, int'(busy[i]), int'(chained));
    if (!chained) chk({name, " idle tx"}, int'(tx[i]), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;

    vt[0] = '{0, 8'hA5, 12'b00_1_10100101_0, 10};
    vt[1] = '{0, 8'h00, 12'b00_1_00000000_0, 10};
    vt[2] = '{0, 8'hFF, 12'b00_1_11111111_0, 10};
    vt[3] = '{1, 8'hA5, 12'b0_1_0_10100101_0, 11};
    vt[4] = '{2, 8'hA5, 12'b0_1_1_10100101_0, 11};
    vt[5] = '{1, 8'h01, 12'b0_1_1_00000001_0, 11};
    vt[6] = '{2, 8'h01, 12'b0_1_0_00000001_0, 11};
    vt[7] = '{3, 8'h3C, 12'b0_11_00111100_0, 11};

    for (int i = 0; i < N; i++) exp_sent[i] = 0;

    // Reset and idle with empty FIFOs.
    en    = '1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx", int'(tx), 'hF);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset pop", int'(rd), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle tx", int'(tx), 'hF);
    chk("idle busy", int'(busy), 0);
    chk("idle pops", rp[0] + rp[1] + rp[2] + rp[3], 0);
    chk("idle count0", int'(sent[0]), 0);
    chk("idle count3", int'(sent[3]), 0);

    // Single frames from the vector table.
    for (int v = 0; v < 8; v++) begin
      push(vt[v].inst, vt[v].data);
      #1;
      chk($sformatf("vec%0d pop", v), int'(rd[vt[v].inst]), 1);
      @(negedge clk);
      run_frame(vt[v].inst, vt[v].frame, vt[v].nbits, 1'b0, -1, $sformatf("vec%0d", v));
    end

    // Enable dropped mid-DATA of the first of three queued bytes.
    base = rp[0];
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    #1;
    chk("drop pop1", int'(rd[0]), 1);
    @(negedge clk);
    run_frame(0, f1(8'h11), 10, 1'b0, 14, "drop f1");
    repeat (8) @(negedge clk);
    chk("drop hold pops", rp[0] - base, 1);
    chk("drop hold busy", int'(busy[0]), 0);
    chk("drop hold tx", int'(tx[0]), 1);
    en[0] = 1'b1;
    #1;
    chk("reenable pop", int'(rd[0]), 1);
    @(negedge clk);
    run_frame(0, f1(8'h22), 10, 1'b1, -1, "drop f2");
    run_frame(0, f1(8'h33), 10, 1'b0, -1, "drop f3");
    chk("drop drained", int'(empty[0]), 1);

    // Sixteen back-to-back frames with two stop bits.
    base = rp[3];
    for (int v = 0; v < 16; v++) push(3, 8'(v));
    #1;
    chk("b2b first pop", int'(rd[3]), 1);
    @(negedge clk);
    for (int v = 0; v < 16; v++)
      run_frame(3, f2(8'(v)), 11, (v != 15), -1, $sformatf("b2b%0d", v));
    chk("b2b pops", rp[3] - base, 16);
    chk("b2b empty", int'(empty[3]), 1);
    chk("b2b count", int'(sent[3]), 17);

    // Reset during data bit 4 of 0x3C; the following byte starts fresh.
    base = rp[0];
    push(0, 8'h3C);
    push(0, 8'h5A);
    #1;
    chk("rst pop", int'(rd[0]), 1);
    @(negedge clk);
    repeat (21) @(negedge clk);
    chk("rst pre busy", int'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("rst tx", int'(tx[0]), 1);
    chk("rst busy", int'(busy[0]), 0);
    chk("rst no pop", int'(rd[0]), 0);
    chk("rst count", int'(sent[3]), 0);
    for (int i = 0; i < N; i++) exp_sent[i] = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst held pops", rp[0] - base, 1);
    rst_n = 1'b1;
    #1;
    chk("post rst pop", int'(rd[0]), 1);
    @(negedge clk);
    run_frame(0, f1(8'h5A), 10, 1'b0, -1, "post rst");

    chk("underflow", int'(uflow), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
